// File: rtl/sdc_dq_pkg.sv
// Shared constants and state encoding for the SDRAM DQ datapath.
// Included by the interface, the byte-lane slice and the top.
package sdc_dq_pkg;

  localparam int LANE_W       = 8;
  localparam int WR_LAT_MAX   = 4;
  localparam int RD_LAT_MAX   = 15;
  localparam int TURN_CYC_MAX = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    TURN  = ST_TURN
  } dq_state_e;

endpackage

// File: rtl/sdc_dq_io_ctrl_if.sv
// Scheduler-facing write/read beat handshake of the DQ datapath.
// master = scheduler side, slave = sdc_dq_io_ctrl.
interface sdc_dq_io_ctrl_if
  import sdc_dq_pkg::*;
#(
  parameter int DQ_WIDTH = 32
);
  localparam int LANES = DQ_WIDTH / LANE_W;

  logic                wr_valid;
  logic                wr_ready;
  logic [DQ_WIDTH-1:0] wr_data;
  logic [LANES-1:0]    wr_mask;
  logic                rd_cmd;
  logic                rd_ready;
  logic                rd_valid;
  logic [DQ_WIDTH-1:0] rd_data;
  logic                busy;

  modport master (
    output wr_valid, wr_data, wr_mask, rd_cmd,
    input  wr_ready, rd_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  wr_valid, wr_data, wr_mask, rd_cmd,
    output wr_ready, rd_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/sdc_dq_lane.sv
// One DQ byte lane: launch register + tristate pad, DM pad, capture register; 1-cycle launch/capture.
// No backpressure; with SDC_DQ_LOOPBACK_EN the capture may take the looped-back byte instead of the pad.
module sdc_dq_lane
  import sdc_dq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drv_en,
  input  logic [LANE_W-1:0] drv_dat,
  input  logic              drv_mask,
  input  logic              cap_en,
`ifdef SDC_DQ_LOOPBACK_EN
  input  logic              lpbk_sel,
  input  logic [LANE_W-1:0] lpbk_dat,
`endif
  output logic              dq_t,
  output logic              dm,
  output logic [LANE_W-1:0] cap_dat,
  inout  wire  [LANE_W-1:0] pad
);

  logic [LANE_W-1:0] dq_o;
  logic [LANE_W-1:0] cap_src;

`ifdef SDC_DQ_LOOPBACK_EN
  assign cap_src = lpbk_sel ? lpbk_dat : pad;
`else
  assign cap_src = pad;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dq_o    <= '0;
      dq_t    <= 1'b1;
      dm      <= 1'b0;
      cap_dat <= '0;
    end else begin
      dq_t <= ~drv_en;
      // a masked lane still drives DQ; only the DM pad marks it
      dm   <= drv_en & drv_mask;
      if (drv_en) dq_o <= drv_dat;
      if (cap_en) cap_dat <= cap_src;
    end
  end

  assign pad = dq_t ? {LANE_W{1'bz}} : dq_o;

endmodule

// File: rtl/sdc_dq_io_ctrl.sv
// DQ datapath between scheduler and pads: writes drive WR_LAT cycles after accept, reads return RD_LAT+1 later.
// wr_ready/rd_ready drop outside the matching direction and during TURN; SDC_DQ_LOOPBACK_EN adds lpbk_en.
module sdc_dq_io_ctrl
  import sdc_dq_pkg::*;
#(
  parameter int DQ_WIDTH = 32,
  parameter int WR_LAT   = 1,
  parameter int RD_LAT   = 3,
  parameter int TURN_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef SDC_DQ_LOOPBACK_EN
  input  logic                       lpbk_en,
`endif
  sdc_dq_io_ctrl_if.slave            bus,
  inout  wire  [DQ_WIDTH-1:0]        sdc_dq,
  output logic [DQ_WIDTH/LANE_W-1:0] sdc_dm
);

  localparam int LANES = DQ_WIDTH / LANE_W;
  localparam logic [RD_LAT-1:0] TOK_HEAD_MASK = {RD_LAT{1'b1}} >> 1;
  localparam dq_state_e POST_ST = (TURN_CYC > 0) ? TURN : IDLE;

  if ((DQ_WIDTH % LANE_W) != 0 || DQ_WIDTH < LANE_W ||
      WR_LAT < 1 || WR_LAT > WR_LAT_MAX || RD_LAT < 1 || RD_LAT > RD_LAT_MAX ||
      TURN_CYC < 0 || TURN_CYC > TURN_CYC_MAX) begin : g_bad_param
    $error("sdc_dq_io_ctrl: parameter out of range");
  end

  typedef struct packed {
    logic [DQ_WIDTH-1:0] dat;
    logic [LANES-1:0]    msk;
  } wr_beat_t;

  dq_state_e       state_q, state_d;
  logic [2:0]      turn_cnt_q, turn_cnt_d;
  logic            wr_ready, rd_ready, wr_acc, rd_acc;
  wr_beat_t        in_beat, exit_beat;
  logic            exit_vld, wr_inflight, pad_drv;
  logic [RD_LAT-1:0] tok_q;
  logic            tok_exit, tok_head, rd_valid_q;
  logic [LANES-1:0]    dq_t;
  logic [DQ_WIDTH-1:0] cap_dat;

  assign wr_ready = (state_q == IDLE) | (state_q == WRITE);
  assign rd_ready = (state_q == READ) | ((state_q == IDLE) & ~bus.wr_valid);
  assign wr_acc   = bus.wr_valid & wr_ready;
  assign rd_acc   = bus.rd_cmd & rd_ready;
  assign in_beat  = '{dat: bus.wr_data, msk: bus.wr_mask};

  // The lane output register is the last write stage, so only WR_LAT-1 stages live here.
  if (WR_LAT == 1) begin : g_wp_bypass
    always_comb begin
      exit_vld    = wr_acc;
      exit_beat   = in_beat;
      wr_inflight = 1'b0;
    end
  end else begin : g_wp
    wr_beat_t          beat_q [WR_LAT-1];
    logic [WR_LAT-2:0] vld_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < WR_LAT - 1; i++) beat_q[i] <= '0;
      end else begin
        vld_q[0]  <= wr_acc;
        beat_q[0] <= in_beat;
        for (int i = 1; i < WR_LAT - 1; i++) begin
          vld_q[i]  <= vld_q[i-1];
          beat_q[i] <= beat_q[i-1];
        end
      end
    end

    always_comb begin
      exit_vld    = vld_q[WR_LAT-2];
      exit_beat   = beat_q[WR_LAT-2];
      wr_inflight = |vld_q;
    end
  end

`ifdef SDC_DQ_LOOPBACK_EN
  logic [DQ_WIDTH-1:0] lpbk_q;

  assign pad_drv = exit_vld & ~lpbk_en;

  always_ff @(posedge clk) begin
    if (!rst_n)                  lpbk_q <= '0;
    else if (exit_vld & lpbk_en) lpbk_q <= exit_beat.dat;
  end
`else
  assign pad_drv = exit_vld;
`endif

  // Tokens enter at bit 0; the pads are sampled on the edge a token leaves the top bit.
  assign tok_exit = tok_q[RD_LAT-1];
  assign tok_head = |(tok_q & TOK_HEAD_MASK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      tok_q      <= (tok_q << 1) | RD_LAT'(rd_acc);
      rd_valid_q <= tok_exit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  // Each direction is left in its last active pad cycle, so TURN starts right after it.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_valid)    state_d = WRITE;
        else if (bus.rd_cmd) state_d = READ;
      end
      WRITE: if (!wr_acc && !wr_inflight) state_d = POST_ST;
      READ:  if (!rd_acc && !tok_head)    state_d = POST_ST;
      TURN: begin
        if (turn_cnt_q <= 3'd1) state_d = IDLE;
        else                    turn_cnt_d = turn_cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == TURN && state_q != TURN) turn_cnt_d = 3'(TURN_CYC);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sdc_dq_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .drv_en   (pad_drv),
      .drv_dat  (exit_beat.dat[i*LANE_W +: LANE_W]),
      .drv_mask (exit_beat.msk[i]),
      .cap_en   (tok_exit),
`ifdef SDC_DQ_LOOPBACK_EN
      .lpbk_sel (lpbk_en),
      .lpbk_dat (lpbk_q[i*LANE_W +: LANE_W]),
`endif
      .dq_t     (dq_t[i]),
      .dm       (sdc_dm[i]),
      .cap_dat  (cap_dat[i*LANE_W +: LANE_W]),
      .pad      (sdc_dq[i*LANE_W +: LANE_W])
    );
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = cap_dat;
  assign bus.busy     = (state_q != IDLE);

  a_no_drive_read_turn: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q inside {READ, TURN}) |-> (&dq_t)
  );

endmodule

// File: tb/tb_sdc_dq_io_ctrl.sv
// Bench for sdc_dq_io_ctrl at default parameters: per-cycle vector table plus hand-written corner sequences.
module tb_sdc_dq_io_ctrl;
  import sdc_dq_pkg::*;

  localparam int DQW = 32;
  localparam int LN  = DQW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdc_dq_io_ctrl_if #(.DQ_WIDTH(DQW)) bus ();
  wire  [DQW-1:0] sdc_dq;
  logic [LN-1:0]  sdc_dm;
  logic           tb_drv_en;
  logic [DQW-1:0] tb_drv_dat;

  assign sdc_dq = tb_drv_en ? tb_drv_dat : {DQW{1'bz}};

`ifdef SDC_DQ_LOOPBACK_EN
  logic lpbk_en;
`endif

  sdc_dq_io_ctrl #(.DQ_WIDTH(DQW), .WR_LAT(1), .RD_LAT(3), .TURN_CYC(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SDC_DQ_LOOPBACK_EN
    .lpbk_en (lpbk_en),
`endif
    .bus     (bus),
    .sdc_dq  (sdc_dq),
    .sdc_dm  (sdc_dm)
  );

  typedef struct {
    logic           rst_n, wv, rc, de;
    logic [DQW-1:0] wd, dd;
    logic [LN-1:0]  wm;
    logic           e_wr_rdy, e_rd_rdy, e_busy, e_rd_vld, e_rel;
    logic [DQW-1:0] e_rd_dat, e_dq;
    logic [LN-1:0]  e_dm;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int r, wv, wd, wm, rc, de, dd,
                              input int ewr, erd, eb, ev, erdat, erel, edq, edm);
    vec_t v;
    v.rst_n = r[0];  v.wv = wv[0];  v.wd = 32'(wd);  v.wm = wm[LN-1:0];
    v.rc = rc[0];    v.de = de[0];  v.dd = 32'(dd);
    v.e_wr_rdy = ewr[0]; v.e_rd_rdy = erd[0]; v.e_busy = eb[0]; v.e_rd_vld = ev[0];
    v.e_rd_dat = 32'(erdat); v.e_rel = erel[0]; v.e_dq = 32'(edq); v.e_dm = edm[LN-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic released();
    return (dut.dq_t == {LN{1'b1}});
  endfunction

  initial begin
    int lat, pulses, drv_seen;
    logic got;

    rst_n = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = '0; bus.wr_mask = '0; bus.rd_cmd = 1'b0;
    tb_drv_en = 1'b0; tb_drv_dat = '0;
`ifdef SDC_DQ_LOOPBACK_EN
    lpbk_en = 1'b0;
`endif

    //                rst wv wd            wm   rc de dd            wr rd bsy vld rd_dat        rel dq            dm
    vecs.push_back(mk(0, 1, 0,            0,   0, 0, 0,            1, 0, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(0, 1, 0,            0,   0, 0, 0,            1, 0, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(0, 1, 0,            0,   0, 0, 0,            1, 0, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            1, 1, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 1, 'h11111111,   2,   0, 0, 0,            1, 0, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 1, 'h22222222,   2,   0, 0, 0,            1, 0, 1, 0, 0,            0, 'h11111111,   2));
    vecs.push_back(mk(1, 1, 'h33333333,   2,   0, 0, 0,            1, 0, 1, 0, 0,            0, 'h22222222,   2));
    vecs.push_back(mk(1, 1, 'h44444444,   2,   0, 0, 0,            1, 0, 1, 0, 0,            0, 'h33333333,   2));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            1, 0, 1, 0, 0,            0, 'h44444444,   2));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 0, 1, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   1, 0, 0,            1, 1, 0, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   1, 0, 0,            0, 1, 1, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 1, 1, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 1, 'hDEADBEEF,   0, 1, 1, 0, 0,            1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 1, 'hCAFEF00D,   0, 1, 1, 1, 'hDEADBEEF,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 0, 1, 1, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            1, 1, 0, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 1, 'h5A5A5A5A,   0,   1, 0, 0,            1, 0, 0, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   1, 0, 0,            1, 0, 1, 0, 'hCAFEF00D,   0, 'h5A5A5A5A,   0));
    vecs.push_back(mk(1, 0, 0,            0,   1, 0, 0,            0, 0, 1, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   1, 0, 0,            1, 1, 0, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 1, 1, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 1, 1, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 1, 'h0BADF00D,   0, 1, 1, 0, 'hCAFEF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 0, 1, 1, 'h0BADF00D,   1, 0,            0));
    vecs.push_back(mk(1, 1, 'hFFFF0000,   'hF, 0, 0, 0,            1, 0, 0, 0, 'h0BADF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            1, 0, 1, 0, 'h0BADF00D,   0, 'hFFFF0000,   'hF));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            0, 0, 1, 0, 'h0BADF00D,   1, 0,            0));
    vecs.push_back(mk(1, 0, 0,            0,   0, 0, 0,            1, 1, 0, 0, 'h0BADF00D,   1, 0,            0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; bus.wr_valid = vecs[i].wv; bus.wr_data = vecs[i].wd;
      bus.wr_mask = vecs[i].wm; bus.rd_cmd = vecs[i].rc;
      tb_drv_en = vecs[i].de; tb_drv_dat = vecs[i].dd;
      #1;
      chk($sformatf("wr_ready@%0d", i), 32'(bus.wr_ready), 32'(vecs[i].e_wr_rdy));
      chk($sformatf("rd_ready@%0d", i), 32'(bus.rd_ready), 32'(vecs[i].e_rd_rdy));
      chk($sformatf("busy@%0d", i),     32'(bus.busy),     32'(vecs[i].e_busy));
      chk($sformatf("rd_valid@%0d", i), 32'(bus.rd_valid), 32'(vecs[i].e_rd_vld));
      chk($sformatf("rd_data@%0d", i),  bus.rd_data,       vecs[i].e_rd_dat);
      chk($sformatf("released@%0d", i), 32'(released()),   32'(vecs[i].e_rel));
      chk($sformatf("sdc_dm@%0d", i),   32'(sdc_dm),       32'(vecs[i].e_dm));
      if (!vecs[i].e_rel) chk($sformatf("sdc_dq@%0d", i), sdc_dq, vecs[i].e_dq);
    end

    // Read latency measured from the accept cycle, pads driven by the bench throughout.
    @(negedge clk);
    bus.rd_cmd = 1'b1; tb_drv_en = 1'b1; tb_drv_dat = 32'h600DCAFE;
    #1 chk("lat_accept_rd_ready", 32'(bus.rd_ready), 32'd1);
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      bus.rd_cmd = 1'b0;
      #1;
      if (bus.rd_valid) begin got = 1'b1; lat = k; end
    end
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_latency_data", bus.rd_data, 32'h600DCAFE);
    tb_drv_en = 1'b0;

    // Reset one cycle after a read accept drops the in-flight beat.
    @(negedge clk);
    bus.rd_cmd = 1'b1;
    #1 chk("rst_mid_accept_rd_ready", 32'(bus.rd_ready), 32'd1);
    @(negedge clk);
    bus.rd_cmd = 1'b0; rst_n = 1'b0;
    #1 chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_busy_after", 32'(bus.busy), 32'd0);
    chk("rst_mid_rd_data", bus.rd_data, 32'd0);
    chk("rst_mid_rd_ready", 32'(bus.rd_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 if (bus.rd_valid) pulses++;
    end
    chk("rst_mid_no_rd_valid", 32'(pulses), 32'd0);

`ifdef SDC_DQ_LOOPBACK_EN
    // Loopback: the write stays off the pads and the read returns it instead of the pad value.
    drv_seen = 0;
    @(negedge clk);
    lpbk_en = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 32'hA5A5A5A5; bus.wr_mask = 4'hF;
    #1 chk("lpbk_wr_ready", 32'(bus.wr_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1 if (!released() || sdc_dm != '0) drv_seen++;
    end
    @(negedge clk);
    bus.rd_cmd = 1'b1; tb_drv_en = 1'b1; tb_drv_dat = 32'h12345678;
    #1 chk("lpbk_rd_ready", 32'(bus.rd_ready), 32'd1);
    got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      bus.rd_cmd = 1'b0;
      #1;
      if (!released() || sdc_dm != '0) drv_seen++;
      if (bus.rd_valid) got = 1'b1;
    end
    chk("lpbk_rd_valid_seen", 32'(got), 32'd1);
    chk("lpbk_rd_data", bus.rd_data, 32'hA5A5A5A5);
    chk("lpbk_pads_released", 32'(drv_seen), 32'd0);
    tb_drv_en = 1'b0; lpbk_en = 1'b0;
`else
    drv_seen = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
